// File: rtl/instruction_fetch_if.sv
// Fetch-stage bundle: control from the pipeline, ROM address/data, and the
// fetched instruction presented to decode.
interface instruction_fetch_if #(
    parameter int unsigned ADDR_WIDTH = 10
) ();
    logic                  stall;
    logic                  halt;
    logic                  redirect;
    logic [31:0]           redirect_pc;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [31:0]           rom_data;
    logic [31:0]           instr;
    logic [31:0]           instr_pc;
    logic                  instr_valid;
    logic                  misaligned;

    modport master (
        input  stall, halt, redirect, redirect_pc, rom_data,
        output rom_addr, instr, instr_pc, instr_valid, misaligned
    );

    modport slave (
        output stall, halt, redirect, redirect_pc, rom_data,
        input  rom_addr, instr, instr_pc, instr_valid, misaligned
    );
endinterface

// File: rtl/instruction_fetch.sv
// MIPS32 fetch front end: owns the PC and drives a synchronous ROM whose
// data lags its address by one edge, with no bubbles on stall or redirect.
module instruction_fetch #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    instruction_fetch_if.master bus
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] ipc_q, ipc_d;
    logic        ivalid_q, ivalid_d;
    logic        mis_q, mis_d;
    logic [31:0] target;

    assign target = {bus.redirect_pc[31:2], 2'b00};

    always_comb begin
        pc_d         = pc_q;
        ipc_d        = ipc_q;
        ivalid_d     = ivalid_q;
        mis_d        = 1'b0;
        bus.rom_addr = pc_q[ADDR_WIDTH+1:2];

        if (bus.redirect) begin
            bus.rom_addr = bus.redirect_pc[ADDR_WIDTH+1:2];
            ipc_d        = target;
            pc_d         = target + 32'd4;
            ivalid_d     = 1'b1;
            mis_d        = |bus.redirect_pc[1:0];
        end else if (bus.stall && ivalid_q) begin
            // Re-read the held word so the ROM output stays stable.
            bus.rom_addr = ipc_q[ADDR_WIDTH+1:2];
        end else if (bus.halt) begin
            ivalid_d = 1'b0;
        end else begin
            ipc_d    = pc_q;
            pc_d     = pc_q + 32'd4;
            ivalid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            ipc_q    <= RESET_PC;
            ivalid_q <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            ipc_q    <= ipc_d;
            ivalid_q <= ivalid_d;
            mis_q    <= mis_d;
        end
    end

    assign bus.instr       = ivalid_q ? bus.rom_data : 32'h0;
    assign bus.instr_pc    = ipc_q;
    assign bus.instr_valid = ivalid_q;
    assign bus.misaligned  = mis_q;

endmodule
